// File: rtl/mac_requant.sv
// Requantisation stage: optional ReLU, rounding arithmetic right shift and
// saturation of a signed accumulator to a signed activation, in a 2-deep pipeline.
module mac_requant #(
    parameter int IN_BIT_RESOLUTION  = 32,
    parameter int OUT_BIT_RESOLUTION = 8,
    parameter int SHIFT_BITS         = 5,
    parameter int CNT_BITS           = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clr_i,
    input  logic                          relu_en_i,
    input  logic [SHIFT_BITS-1:0]         shift_i,
    input  logic                          mac_valid_i,
    input  logic [IN_BIT_RESOLUTION-1:0]  mac_data_i,
    output logic                          mac_ready_o,
    output logic                          act_valid_o,
    output logic [OUT_BIT_RESOLUTION-1:0] act_data_o,
    input  logic                          act_ready_i,
    output logic [CNT_BITS-1:0]           sat_count_o
);

    // One guard bit so that x + 2^(shift-1) cannot overflow.
    localparam int W1 = IN_BIT_RESOLUTION + 1;
    localparam logic signed [W1-1:0] ACT_MAX = W1'((2 ** (OUT_BIT_RESOLUTION - 1)) - 1);
    localparam logic signed [W1-1:0] ACT_MIN = W1'(-(2 ** (OUT_BIT_RESOLUTION - 1)));

    function automatic logic signed [W1-1:0] requant(
        input logic [IN_BIT_RESOLUTION-1:0] data,
        input logic                         relu,
        input logic [SHIFT_BITS-1:0]        shamt
    );
        logic signed [W1-1:0] x;
        logic signed [W1-1:0] rnd;
        x   = (relu && data[IN_BIT_RESOLUTION-1]) ? {W1{1'b0}} : W1'($signed(data));
        rnd = (shamt == {SHIFT_BITS{1'b0}}) ? {W1{1'b0}}
                                            : (W1'(1) << (shamt - {{(SHIFT_BITS-1){1'b0}}, 1'b1}));
        return (x + rnd) >>> shamt;
    endfunction

    function automatic logic is_sat(input logic signed [W1-1:0] y);
        return (y > ACT_MAX) || (y < ACT_MIN);
    endfunction

    function automatic logic [OUT_BIT_RESOLUTION-1:0] clamp(input logic signed [W1-1:0] y);
        logic signed [W1-1:0] c;
        c = (y > ACT_MAX) ? ACT_MAX : ((y < ACT_MIN) ? ACT_MIN : y);
        return c[OUT_BIT_RESOLUTION-1:0];
    endfunction

    logic                          s1_v_q, s1_v_d;
    logic signed [W1-1:0]          s1_y_q, s1_y_d;
    logic                          s2_v_q, s2_v_d;
    logic [OUT_BIT_RESOLUTION-1:0] act_q, act_d;
    logic [CNT_BITS-1:0]           sat_cnt_q, sat_cnt_d;
    logic                          s1_ready_s, s2_ready_s, in_fire_s, s1_adv_s;

    // Handshake and stall network; ready is combinational from act_ready_i.
    always_comb begin
        s2_ready_s  = !s2_v_q || act_ready_i;
        s1_ready_s  = !s1_v_q || s2_ready_s;
        mac_ready_o = s1_ready_s && !clr_i;
        in_fire_s   = mac_valid_i && mac_ready_o;
        s1_adv_s    = s1_v_q && s2_ready_s;
    end

    // Next-state for both stages and the saturation counter; clear wins.
    always_comb begin
        s1_v_d    = s1_v_q;
        s1_y_d    = s1_y_q;
        s2_v_d    = s2_v_q;
        act_d     = act_q;
        sat_cnt_d = sat_cnt_q;
        if (clr_i) begin
            s1_v_d    = 1'b0;
            s2_v_d    = 1'b0;
            sat_cnt_d = {CNT_BITS{1'b0}};
        end else begin
            if (s1_ready_s) begin
                s1_v_d = in_fire_s;
            end else begin
                s1_v_d = s1_v_q;
            end
            if (in_fire_s) begin
                s1_y_d = requant(mac_data_i, relu_en_i, shift_i);
            end else begin
                s1_y_d = s1_y_q;
            end
            if (s2_ready_s) begin
                s2_v_d = s1_v_q;
            end else begin
                s2_v_d = s2_v_q;
            end
            if (s1_adv_s) begin
                act_d = clamp(s1_y_q);
                if (is_sat(s1_y_q) && (sat_cnt_q != {CNT_BITS{1'b1}})) begin
                    sat_cnt_d = sat_cnt_q + {{(CNT_BITS-1){1'b0}}, 1'b1};
                end else begin
                    sat_cnt_d = sat_cnt_q;
                end
            end else begin
                act_d = act_q;
            end
        end
    end

    // Pipeline and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_v_q    <= 1'b0;
            s1_y_q    <= {W1{1'b0}};
            s2_v_q    <= 1'b0;
            act_q     <= {OUT_BIT_RESOLUTION{1'b0}};
            sat_cnt_q <= {CNT_BITS{1'b0}};
        end else begin
            s1_v_q    <= s1_v_d;
            s1_y_q    <= s1_y_d;
            s2_v_q    <= s2_v_d;
            act_q     <= act_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign act_valid_o = s2_v_q;
    assign act_data_o  = act_q;
    assign sat_count_o = sat_cnt_q;

endmodule

// File: tb/tb_mac_requant.sv
// Scoreboard bench for mac_requant: driver pushes expected activations,
// a monitor pops and compares on every output transfer.
module tb_mac_requant;

    logic        clk = 1'b0;
    logic        rst_ni, clr_i, relu_en_i, mac_valid_i, act_ready_i;
    logic [4:0]  shift_i;
    logic [31:0] mac_data_i;
    logic        mac_ready_o, act_valid_o;
    logic [7:0]  act_data_o;
    logic [15:0] sat_count_o;

    mac_requant #(.IN_BIT_RESOLUTION(32), .OUT_BIT_RESOLUTION(8), .SHIFT_BITS(5), .CNT_BITS(16)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clr_i(clr_i), .relu_en_i(relu_en_i), .shift_i(shift_i),
        .mac_valid_i(mac_valid_i), .mac_data_i(mac_data_i), .mac_ready_o(mac_ready_o),
        .act_valid_o(act_valid_o), .act_data_o(act_data_o), .act_ready_i(act_ready_i),
        .sat_count_o(sat_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint d;
        bit     sat;
        int     acc;
    } exp_t;

    typedef struct {
        logic [31:0] d;
        int          s;
        bit          r;
        int          e;
        bit          sat;
    } dir_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   sat_exp = 0;
    bit   lat_chk = 1'b0;
    bit   bp_on   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic signed [63:0] act, logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: ReLU, round-half-up division by 2^s using floor division, clamp.
    function automatic exp_t model(logic [31:0] d, int s, bit r);
        exp_t   e;
        longint x, p, n, y;
        x = longint'($signed(d));
        if (r && x < 0) x = 0;
        p = longint'(1) << s;
        n = x + p / 2;
        y = n / p;
        if ((n % p != 0) && (n < 0)) y = y - 1;
        e.d   = (y > 127) ? 127 : ((y < -128) ? -128 : y);
        e.sat = (e.d != y);
        e.acc = 0;
        return e;
    endfunction

    task automatic send(input logic [31:0] d, input int s, input bit r,
                        input bit use_e, input int ed, input bit esat);
        exp_t e;
        mac_data_i  = d;
        shift_i     = s[4:0];
        relu_en_i   = r;
        mac_valid_i = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mac_ready_o) begin
                e = model(d, s, r);
                if (use_e) begin
                    e.d   = ed;
                    e.sat = esat;
                end
                e.acc = cyc + 1;
                q.push_back(e);
                if (e.sat) sat_exp++;
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        total++;
        bad++;
        $display("FAIL send_timeout: beat %0d never accepted", $signed(d));
        mac_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d beats still expected", q.size());
            q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
        chk("sat_count", sat_count_o, sat_exp);
    endtask

    // Monitor: one comparison per output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (rst_ni && act_valid_o && act_ready_i) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got %0d with nothing expected", $signed(act_data_o));
            end else begin
                e = q.pop_front();
                chk("act_data", $signed(act_data_o), e.d);
                if (lat_chk) chk("latency", cyc - e.acc, 1);
            end
        end
    end

    dir_t dirs[6] = '{
        '{32'd145,        1, 1'b1,  73,  1'b0},
        '{32'd145,        0, 1'b0,  127, 1'b1},
        '{-32'sd1000,     0, 1'b0, -128, 1'b1},
        '{-32'sd300,      2, 1'b1,  0,   1'b0},
        '{-32'sd300,      2, 1'b0, -75,  1'b0},
        '{32'h7FFF_FFFF, 31, 1'b0,  1,   1'b0}
    };

    task automatic fill_then_stall();
        for (int i = 0; i < 3; i++) send(32'd1000, 0, 1'b0, 1'b1, 127, 1'b1);
        mac_valid_i = 1'b0;
        drain();
        act_ready_i = 1'b0;
        send(32'd5, 0, 1'b0, 1'b1, 5, 1'b0);
        send(32'd6, 0, 1'b0, 1'b1, 6, 1'b0);
        mac_data_i = 32'd7;
    endtask

    initial begin
        int n;
        rst_ni = 1'b0; clr_i = 1'b0; relu_en_i = 1'b0; mac_valid_i = 1'b0;
        shift_i = 5'd0; mac_data_i = 32'd0; act_ready_i = 1'b1;
        #1;
        chk("rst_act_valid", act_valid_o, 0);
        chk("rst_act_data", act_data_o, 0);
        chk("rst_sat_count", sat_count_o, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        #1;
        chk("rst_mac_ready", mac_ready_o, 1);

        // Directed values with hand-computed expectations.
        lat_chk = 1'b1;
        foreach (dirs[i]) begin
            send(dirs[i].d, dirs[i].s, dirs[i].r, 1'b1, dirs[i].e, dirs[i].sat);
            mac_valid_i = 1'b0;
            drain();
            chk("ready_idle", mac_ready_o, 1);
        end

        // Backpressure: only two beats fit while the output is stalled.
        lat_chk = 1'b0;
        act_ready_i = 1'b0;
        fork
            begin
                send(32'd10, 0, 1'b0, 1'b1, 10, 1'b0);
                send(32'd20, 0, 1'b0, 1'b1, 20, 1'b0);
                send(32'd30, 0, 1'b0, 1'b1, 30, 1'b0);
                mac_valid_i = 1'b0;
            end
        join_none
        repeat (2) @(posedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("bp_mac_ready", mac_ready_o, 0);
            chk("bp_act_valid", act_valid_o, 1);
            chk("bp_hold_data", act_data_o, 10);
            chk("bp_accepted", q.size(), 2);
        end
        @(posedge clk);
        #1;
        act_ready_i = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_drain_cycles", n, 3);
        wait fork;
        drain();

        // Back-to-back stream with exact latency.
        lat_chk = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 1) send($urandom, $urandom_range(0, 31), 1'($urandom_range(0, 1)), 1'b0, 0, 1'b0);
            else send(32'($signed($urandom_range(0, 4000)) - 2000), $urandom_range(0, 4),
                      1'($urandom_range(0, 1)), 1'b0, 0, 1'b0);
        end
        mac_valid_i = 1'b0;
        drain();
        lat_chk = 1'b0;

        // Synchronous clear with two beats in flight.
        clr_i = 1'b1;
        @(posedge clk);
        #1;
        clr_i = 1'b0;
        q.delete();
        sat_exp = 0;
        fill_then_stall();
        chk("pre_clr_sat", sat_count_o, 3);
        mac_valid_i = 1'b1;
        clr_i = 1'b1;
        #1;
        chk("clr_mac_ready", mac_ready_o, 0);
        @(posedge clk);
        #1;
        chk("clr_act_valid", act_valid_o, 0);
        chk("clr_sat_count", sat_count_o, 0);
        clr_i = 1'b0;
        mac_valid_i = 1'b0;
        q.delete();
        sat_exp = 0;
        act_ready_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_clr_empty", act_valid_o, 0);

        // Asynchronous reset with two beats in flight.
        fill_then_stall();
        chk("pre_rst_sat", sat_count_o, 3);
        mac_valid_i = 1'b1;
        @(negedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_act_valid", act_valid_o, 0);
        chk("arst_sat_count", sat_count_o, 0);
        chk("arst_act_data", act_data_o, 0);
        q.delete();
        sat_exp = 0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        mac_valid_i = 1'b0;
        act_ready_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_empty", act_valid_o, 0);

        // Random traffic with random backpressure and per-beat shift/relu.
        bp_on = 1'b1;
        fork
            while (bp_on) begin
                @(posedge clk);
                #1;
                act_ready_i = ($urandom_range(0, 3) != 0);
            end
        join_none
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                mac_valid_i = 1'b0;
                @(posedge clk);
                #1;
            end
            case ($urandom_range(0, 2))
                0: send($urandom, $urandom_range(0, 31), 1'($urandom_range(0, 1)), 1'b0, 0, 1'b0);
                1: send(32'($signed($urandom_range(0, 2000)) - 1000), $urandom_range(0, 3),
                        1'($urandom_range(0, 1)), 1'b0, 0, 1'b0);
                default: send(32'($signed($urandom_range(0, 200000)) - 100000), $urandom_range(8, 12),
                              1'($urandom_range(0, 1)), 1'b0, 0, 1'b0);
            endcase
        end
        mac_valid_i = 1'b0;
        bp_on = 1'b0;
        wait fork;
        act_ready_i = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
